// File: rtl/onchip_path_reader.sv
// onchip_path_reader
//   Consumer side of the on-chip path SRAM (64x16 dual-port). Masters SRAM port s2:
//   reads the header word, then each waypoint word in turn, streams every waypoint
//   out on a valid/ready interface, and finally writes 0 back to the header so the
//   HPS can see that the slot is free again.
//
// Ports
//   clk, reset        single clock; synchronous active-high reset
//   start             one-cycle request to consume a block (ignored unless idle)
//   sram_*            port s2 master: address/chipselect/write/byteenable/writedata/clken
//                     are registered outputs; sram_readdata is valid one cycle after
//                     the address cycle
//   wp_data/valid     waypoint stream to the motion controller, wp_ready from it
//   busy              high whenever the FSM is not idle
//   done              one-cycle pulse at the end of every block
//   wp_count          waypoint count latched from the header

module onchip_path_reader #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned HDR_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] sram_address,
    output logic              sram_chipselect,
    output logic              sram_write,
    output logic [1:0]        sram_byteenable,
    output logic [DATA_W-1:0] sram_writedata,
    output logic              sram_clken,
    input  logic [DATA_W-1:0] sram_readdata,
    output logic [DATA_W-1:0] wp_data,
    output logic              wp_valid,
    input  logic              wp_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] wp_count
);

    localparam logic [ADDR_W-1:0] HdrAddr = ADDR_W'(HDR_ADDR);

    typedef enum logic [2:0] {
        StIdle,
        StRdHdr,
        StHdrWait,
        StRdWp,
        StWpWait,
        StOut,
        StClr,
        StDone
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    // Next-state logic. The SRAM strobes and stream outputs are decoded from the
    // next state and registered, so they line up exactly with the state they belong to.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        data_d  = data_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRdHdr;
                end
            end
            StRdHdr: begin
                state_d = StHdrWait;
            end
            StHdrWait: begin
                // Only the low ADDR_W bits are the count; upper header bits are ignored.
                count_d = sram_readdata[ADDR_W-1:0];
                if (sram_readdata[ADDR_W-1:0] == '0) begin
                    state_d = StDone;
                end else begin
                    idx_d   = ADDR_W'(1);
                    state_d = StRdWp;
                end
            end
            StRdWp: begin
                state_d = StWpWait;
            end
            StWpWait: begin
                data_d  = sram_readdata;
                state_d = StOut;
            end
            StOut: begin
                if (wp_ready) begin
                    if (idx_q == count_q) begin
                        state_d = StClr;
                    end else begin
                        // idx never exceeds count, so it cannot wrap here.
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = StRdWp;
                    end
                end
            end
            StClr: begin
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        cs_d    = (state_d == StRdHdr) || (state_d == StRdWp) || (state_d == StClr);
        we_d    = (state_d == StClr);
        addr_d  = '0;
        if (state_d == StRdWp) begin
            addr_d = HdrAddr + idx_d;
        end else if (cs_d) begin
            addr_d = HdrAddr;
        end
        valid_d = (state_d == StOut);
        done_d  = (state_d == StDone);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign sram_address    = addr_q;
    assign sram_chipselect = cs_q;
    assign sram_write      = we_q;
    assign sram_byteenable = {2{cs_q}};
    assign sram_writedata  = '0;
    assign sram_clken      = 1'b1;
    assign wp_data         = data_q;
    assign wp_valid        = valid_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign wp_count        = count_q;

endmodule

// File: tb/tb_onchip_path_reader.sv
// Directed testbench for onchip_path_reader. A behavioural 64x16 dual-port SRAM
// sits on port s2; the bench loads it through a separate s1-style port.
// Cycle numbering: cycle 0 is the cycle right after the edge that samples start.

module tb_onchip_path_reader;

    localparam int MAXC = 400;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  sram_address;
    logic        sram_chipselect;
    logic        sram_write;
    logic [1:0]  sram_byteenable;
    logic [15:0] sram_writedata;
    logic        sram_clken;
    logic [15:0] sram_readdata;
    logic [15:0] wp_data;
    logic        wp_valid;
    logic        wp_ready = 1'b1;
    logic        busy;
    logic        done;
    logic [5:0]  wp_count;

    // bench-side write port into the SRAM model
    logic        s1_we = 1'b0;
    logic [5:0]  s1_addr = '0;
    logic [15:0] s1_data = '0;
    logic [15:0] mem [0:63];
    logic [15:0] rdata_q = '0;

    int errors = 0;
    int checks = 0;

    // run log
    int          beat_data[$];
    int          beat_cyc[$];
    int          rd_addr[$];
    int          rd_cyc[$];
    int          wr_cnt, wr_addr, wr_cyc, wr_be;
    int          done_cnt, done_cyc, last_k;
    logic [15:0] v_data  [0:MAXC-1];
    bit          v_valid [0:MAXC-1];
    bit          v_busy  [0:MAXC-1];
    bit          v_cs    [0:MAXC-1];

    always #5 clk = ~clk;

    onchip_path_reader #(
        .ADDR_W  (6),
        .DATA_W  (16),
        .HDR_ADDR(0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .sram_address   (sram_address),
        .sram_chipselect(sram_chipselect),
        .sram_write     (sram_write),
        .sram_byteenable(sram_byteenable),
        .sram_writedata (sram_writedata),
        .sram_clken     (sram_clken),
        .sram_readdata  (sram_readdata),
        .wp_data        (wp_data),
        .wp_valid       (wp_valid),
        .wp_ready       (wp_ready),
        .busy           (busy),
        .done           (done),
        .wp_count       (wp_count)
    );

    // SRAM model: read data registered one cycle after the address cycle
    always @(posedge clk) begin
        if (s1_we) mem[s1_addr] <= s1_data;
        if (sram_clken && sram_chipselect) begin
            if (sram_write) begin
                if (sram_byteenable == 2'b11) mem[sram_address] <= sram_writedata;
            end else begin
                rdata_q <= mem[sram_address];
            end
        end
    end
    assign sram_readdata = rdata_q;

    task automatic hps_write(input int addr, input int data);
        @(posedge clk); #1;
        s1_we   = 1'b1;
        s1_addr = 6'(addr);
        s1_data = 16'(data);
        @(posedge clk); #1;
        s1_we   = 1'b0;
    endtask

    // Pulses start, then steps cycle by cycle logging DUT activity at the negedge.
    // wp_ready is low in cycles [stall_at, stall_at+stall_len); start is re-pulsed
    // in cycle restart_at and reset asserted in cycle reset_at (-1 disables).
    task automatic run_block(input int stall_at, input int stall_len, input int restart_at,
                             input int reset_at, input int max_cyc);
        beat_data.delete(); beat_cyc.delete(); rd_addr.delete(); rd_cyc.delete();
        wr_cnt = 0; wr_addr = -1; wr_cyc = -1; wr_be = -1;
        done_cnt = 0; done_cyc = -1; last_k = -1;
        for (int i = 0; i < MAXC; i++) begin
            v_data[i] = '0; v_valid[i] = 0; v_busy[i] = 0; v_cs[i] = 0;
        end
        @(posedge clk); #1;
        start    = 1'b1;
        wp_ready = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < max_cyc; k++) begin
            wp_ready = !(k >= stall_at && k < stall_at + stall_len);
            start    = (k == restart_at);
            reset    = (k == reset_at);
            @(negedge clk);
            last_k     = k;
            v_data[k]  = wp_data;
            v_valid[k] = wp_valid;
            v_busy[k]  = busy;
            v_cs[k]    = sram_chipselect;
            if (wp_valid && wp_ready) begin
                beat_data.push_back(int'(wp_data));
                beat_cyc.push_back(k);
            end
            if (sram_chipselect) begin
                if (sram_write) begin
                    wr_cnt++; wr_addr = int'(sram_address); wr_cyc = k;
                    wr_be = int'(sram_byteenable);
                end else begin
                    rd_addr.push_back(int'(sram_address));
                    rd_cyc.push_back(k);
                end
            end
            if (done) begin
                done_cnt++; done_cyc = k;
            end
            if (done_cyc >= 0 && k >= done_cyc + 3) break;
            @(posedge clk); #1;
        end
        start    = 1'b0;
        reset    = 1'b0;
        wp_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (sram_clken !== 1'b1) begin errors++; $display("FAIL reset_clken: got %b want 1", sram_clken); end
        checks++; if (sram_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b want 0", sram_chipselect); end
        checks++; if (sram_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", sram_write); end
        checks++; if (sram_address !== 6'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", sram_address); end
        checks++; if (sram_byteenable !== 2'b00) begin errors++; $display("FAIL reset_be: got %b want 00", sram_byteenable); end
        checks++; if (wp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", wp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (wp_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", wp_count); end
        checks++; if (wp_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", wp_data); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int exp_d[3] = '{'h1111, 'h2222, 'h3333};
        int exp_c[3] = '{4, 7, 10};
        int exp_ra[4] = '{0, 1, 2, 3};
        int exp_rc[4] = '{0, 2, 5, 8};
        hps_write(0, 'h0003); hps_write(1, 'h1111); hps_write(2, 'h2222); hps_write(3, 'h3333);
        run_block(-1, 0, -1, -1, 60);
        checks++; if (beat_data.size() != 3) begin errors++; $display("FAIL basic_nbeats: got %0d want 3", beat_data.size()); end
        for (int i = 0; i < 3 && i < beat_data.size(); i++) begin
            checks++;
            if (beat_data[i] != exp_d[i] || beat_cyc[i] != exp_c[i]) begin
                errors++;
                $display("FAIL basic_beat%0d: got %h@%0d want %h@%0d", i, beat_data[i], beat_cyc[i], exp_d[i], exp_c[i]);
            end
        end
        checks++; if (rd_addr.size() != 4) begin errors++; $display("FAIL basic_nreads: got %0d want 4", rd_addr.size()); end
        for (int i = 0; i < 4 && i < rd_addr.size(); i++) begin
            checks++;
            if (rd_addr[i] != exp_ra[i] || rd_cyc[i] != exp_rc[i]) begin
                errors++;
                $display("FAIL basic_read%0d: got a%0d@%0d want a%0d@%0d", i, rd_addr[i], rd_cyc[i], exp_ra[i], exp_rc[i]);
            end
        end
        checks++; if (wr_cnt != 1 || wr_addr != 0 || wr_cyc != 11 || wr_be != 3) begin errors++;
            $display("FAIL basic_clear: got n%0d a%0d @%0d be%0d want n1 a0 @11 be3", wr_cnt, wr_addr, wr_cyc, wr_be); end
        checks++; if (done_cnt != 1 || done_cyc != 12) begin errors++;
            $display("FAIL basic_done: got n%0d @%0d want n1 @12", done_cnt, done_cyc); end
        checks++; if (mem[0] !== 16'h0) begin errors++; $display("FAIL basic_hdr: got %h want 0000", mem[0]); end
        checks++; if (wp_count !== 6'd3) begin errors++; $display("FAIL basic_count: got %0d want 3", wp_count); end
        checks++; if (v_busy[0] !== 1'b1) begin errors++; $display("FAIL basic_busy0: got %b want 1", v_busy[0]); end
    endtask

    task automatic test_stall();
        int vcnt = 0;
        int cs_stall = 0;
        int exp_c[3] = '{4, 12, 15};
        hps_write(0, 'h0003);
        run_block(7, 5, -1, -1, 60);
        for (int k = 7; k <= 12; k++) begin
            if (v_valid[k] && v_data[k] == 16'h2222) vcnt++;
            if (v_cs[k]) cs_stall++;
        end
        checks++; if (vcnt != 6) begin errors++; $display("FAIL stall_hold: got %0d want 6", vcnt); end
        checks++; if (v_valid[13] !== 1'b0) begin errors++; $display("FAIL stall_drop: got %b want 0", v_valid[13]); end
        checks++; if (cs_stall != 0) begin errors++; $display("FAIL stall_noaccess: got %0d want 0", cs_stall); end
        checks++; if (beat_cyc.size() != 3) begin errors++; $display("FAIL stall_nbeats: got %0d want 3", beat_cyc.size()); end
        for (int i = 0; i < 3 && i < beat_cyc.size(); i++) begin
            checks++; if (beat_cyc[i] != exp_c[i]) begin errors++;
                $display("FAIL stall_beat%0d: got @%0d want @%0d", i, beat_cyc[i], exp_c[i]); end
        end
        checks++; if (wr_cyc != 16 || done_cyc != 17) begin errors++;
            $display("FAIL stall_end: got wr@%0d done@%0d want wr@16 done@17", wr_cyc, done_cyc); end
    endtask

    task automatic test_zero();
        int vcnt = 0;
        hps_write(0, 'h0040);
        run_block(-1, 0, -1, -1, 30);
        for (int k = 0; k <= last_k; k++) if (v_valid[k]) vcnt++;
        checks++; if (vcnt != 0) begin errors++; $display("FAIL zero_valid: got %0d want 0", vcnt); end
        checks++; if (wr_cnt != 0) begin errors++; $display("FAIL zero_write: got %0d want 0", wr_cnt); end
        checks++; if (done_cnt != 1 || done_cyc != 2) begin errors++;
            $display("FAIL zero_done: got n%0d @%0d want n1 @2", done_cnt, done_cyc); end
        checks++; if (mem[0] !== 16'h0040) begin errors++; $display("FAIL zero_hdr: got %h want 0040", mem[0]); end
        checks++; if (wp_count !== 6'd0) begin errors++; $display("FAIL zero_count: got %0d want 0", wp_count); end
    endtask

    task automatic test_full();
        int bad = 0;
        hps_write(0, 'h003F);
        for (int i = 1; i < 64; i++) hps_write(i, i);
        run_block(-1, 0, -1, -1, 300);
        checks++; if (beat_data.size() != 63) begin errors++; $display("FAIL full_nbeats: got %0d want 63", beat_data.size()); end
        for (int i = 0; i < beat_data.size(); i++) if (beat_data[i] != i + 1) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL full_order: got %0d wrong beats want 0", bad); end
        checks++; if (rd_addr.size() == 0 || rd_addr[rd_addr.size()-1] != 63) begin errors++;
            $display("FAIL full_lastaddr: got %0d want 63", rd_addr.size() == 0 ? -1 : rd_addr[rd_addr.size()-1]); end
        checks++; if (wr_cnt != 1 || wr_addr != 0) begin errors++;
            $display("FAIL full_clear: got n%0d a%0d want n1 a0", wr_cnt, wr_addr); end
        checks++; if (done_cyc != 192) begin errors++; $display("FAIL full_done: got @%0d want @192", done_cyc); end
        checks++; if (mem[0] !== 16'h0) begin errors++; $display("FAIL full_hdr: got %h want 0000", mem[0]); end
        checks++; if (wp_count !== 6'd63) begin errors++; $display("FAIL full_count: got %0d want 63", wp_count); end
    endtask

    task automatic test_reset_mid();
        int cs_after = 0;
        hps_write(0, 'h0003); hps_write(1, 'h1111); hps_write(2, 'h2222); hps_write(3, 'h3333);
        run_block(-1, 0, -1, 5, 20);
        for (int k = 6; k <= last_k; k++) if (v_cs[k]) cs_after++;
        checks++; if (beat_data.size() != 1) begin errors++; $display("FAIL rst_nbeats: got %0d want 1", beat_data.size()); end
        checks++; if (v_busy[6] !== 1'b0 || v_valid[6] !== 1'b0) begin errors++;
            $display("FAIL rst_idle: got busy%b valid%b want busy0 valid0", v_busy[6], v_valid[6]); end
        checks++; if (cs_after != 0) begin errors++; $display("FAIL rst_noaccess: got %0d want 0", cs_after); end
        checks++; if (wr_cnt != 0 || done_cnt != 0) begin errors++;
            $display("FAIL rst_nowrite: got wr%0d done%0d want wr0 done0", wr_cnt, done_cnt); end
        checks++; if (mem[0] !== 16'h0003) begin errors++; $display("FAIL rst_hdr: got %h want 0003", mem[0]); end
    endtask

    task automatic test_back_to_back();
        // header still 0x0003 from the interrupted block
        run_block(4, 3, 5, -1, 60);
        checks++; if (done_cnt != 1 || done_cyc != 15) begin errors++;
            $display("FAIL restart_done: got n%0d @%0d want n1 @15", done_cnt, done_cyc); end
        checks++; if (beat_data.size() != 3 || beat_data[2] != 'h3333) begin errors++;
            $display("FAIL restart_beats: got %0d beats want 3 ending 3333", beat_data.size()); end
        checks++; if (v_busy[last_k] !== 1'b0) begin errors++; $display("FAIL restart_idle: got %b want 0", v_busy[last_k]); end
        hps_write(0, 'h0002); hps_write(1, 'hAAAA); hps_write(2, 'hBBBB);
        run_block(-1, 0, -1, -1, 40);
        checks++; if (beat_data.size() != 2 || beat_data[0] != 'hAAAA || beat_data[1] != 'hBBBB
                      || beat_cyc[0] != 4 || beat_cyc[1] != 7) begin errors++;
            $display("FAIL second_beats: got %0d beats want AAAA@4 BBBB@7", beat_data.size()); end
        checks++; if (wr_cyc != 8 || done_cyc != 9 || done_cnt != 1) begin errors++;
            $display("FAIL second_end: got wr@%0d done@%0d n%0d want wr@8 done@9 n1", wr_cyc, done_cyc, done_cnt); end
        checks++; if (mem[0] !== 16'h0) begin errors++; $display("FAIL second_hdr: got %h want 0000", mem[0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_full();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
